exec_ctl: RTL and testbench

//  Parametrised execute-stage sequencer; successor to the combinational block/wr_reg gating of the exec stage.

---
 rtl/exec_ctl_pkg.sv | 49 ++++
 rtl/exec_ctl_memif.sv | 75 +++++++
 rtl/exec_ctl.sv | 165 ++++++++++++++++
 tb/tb_exec_ctl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctl_pkg.sv
// Shared definitions for the execute-stage sequencer: microinstruction field
// positions, FSM state type and the decoded control-field view of an ir word.
package exec_ctl_pkg;

  localparam int unsigned IR_WE     = 0;
  localparam int unsigned IR_WR     = 1;
  localparam int unsigned IR_WR_CND = 2;
  localparam int unsigned IR_HIGH   = 3;
  localparam int unsigned IR_WRFL   = 4;
  localparam int unsigned IR_BYTEOP = 5;
  localparam int unsigned IR_MEM_OP = 6;
  localparam int unsigned IR_M_IO   = 7;

  localparam int unsigned TMO_DEFAULT = 200;

  typedef enum logic [2:0] {
    EXC_IDLE,
    EXC_EXEC,
    EXC_MEM,
    EXC_WB,
    EXC_FAULT
  } exc_state_e;

  typedef struct packed {
    logic we;
    logic wr;
    logic wr_cnd;
    logic high;
    logic wrfl;
    logic byteop;
    logic mem_op;
    logic m_io;
  } uop_t;

  // All control fields live in the low byte of the microinstruction.
  function automatic uop_t decode_uop(input logic [7:0] f);
    uop_t u;
    u.we     = f[IR_WE];
    u.wr     = f[IR_WR];
    u.wr_cnd = f[IR_WR_CND];
    u.high   = f[IR_HIGH];
    u.wrfl   = f[IR_WRFL];
    u.byteop = f[IR_BYTEOP];
    u.mem_op = f[IR_MEM_OP];
    u.m_io   = f[IR_M_IO];
    return u;
  endfunction

endpackage

// File: rtl/exec_ctl_memif.sv
// Memory-bus side of the execute stage: request/field registers, request hold,
// bus timeout counter and the read-data latch.
module exec_ctl_memif #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              io,
  input  logic              byteop,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              timeout
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TMO_MAX);

  logic [TMO_W-1:0] cnt;

  assign done = active & ack;
  // Timeout fires in the cycle that would make the count reach TMO_MAX; an ack in that cycle wins.
  assign timeout = active & ~ack & (cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_io    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= we;
      mem_io    <= io;
      mem_byte  <= byteop;
      mem_addr  <= addr;
      mem_wdata <= wdata;
      cnt       <= '0;
    end else begin
      if (done || timeout) begin
        mem_req <= 1'b0;
      end
      if (active && !ack && cnt != TMO_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (done && !mem_we) begin
      rd_data <= mem_byte ? {{(DATA_W-8){1'b0}}, rdata[7:0]} : rdata;
    end
  end

endmodule

// File: rtl/exec_ctl.sv
// Execute-stage sequencer: accepts decoded microinstructions, steps them through
// EXEC/MEM/WB, drives regfile/flag write strobes and reports divide/bus faults.
module exec_ctl
  import exec_ctl_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned IR_W    = 36,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dive,
  input  logic              jmp,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_reg,
  output logic              wb_high,
  output logic              wb_flags,
  output logic [DATA_W-1:0] wb_data,
  output logic              div_exc,
  output logic              bus_err,
  input  logic              fault_clr
);

  exc_state_e        state, state_nx;
  uop_t              uop;
  uop_t              in_uop;
  logic              wr_en;
  logic              wr_en_q;
  logic [DATA_W-1:0] alu_res_q;
  logic              div_trap;
  logic              accept;
  logic              mem_start;
  logic              mem_done;
  logic              mem_timeout;
  logic [DATA_W-1:0] rd_data;
  logic              unused_ir;

  assign in_uop    = decode_uop(ir[7:0]);
  assign unused_ir = ^ir[IR_W-1:8];

  assign wr_en    = uop.wr | (uop.wr_cnd & jmp);
  assign div_trap = dive & uop.wr & ~uop.mem_op;

  // A plain register op completes in EXEC, so the next ir can be taken in the same cycle.
  assign ir_ready = (state == EXC_IDLE) ||
                    ((state == EXC_EXEC) && !uop.mem_op && !div_trap);
  assign accept   = ir_valid & ir_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EXC_IDLE;
      uop       <= '0;
      wr_en_q   <= 1'b0;
      alu_res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        uop <= in_uop;
      end
      if (mem_start) begin
        wr_en_q   <= wr_en;
        alu_res_q <= alu_res;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_start = 1'b0;
    wb_reg    = 1'b0;
    wb_high   = 1'b0;
    wb_flags  = 1'b0;
    wb_data   = '0;
    div_exc   = 1'b0;
    bus_err   = 1'b0;
    case (state)
      EXC_IDLE: begin
        if (accept) state_nx = EXC_EXEC;
      end
      EXC_EXEC: begin
        if (uop.mem_op) begin
          mem_start = 1'b1;
          state_nx  = EXC_MEM;
        end else if (div_trap) begin
          div_exc  = 1'b1;
          state_nx = EXC_IDLE;
        end else begin
          wb_reg   = wr_en;
          wb_high  = uop.high;
          wb_flags = uop.wrfl;
          wb_data  = alu_res;
          state_nx = accept ? EXC_EXEC : EXC_IDLE;
        end
      end
      EXC_MEM: begin
        if (mem_done) begin
          if (uop.we) begin
            wb_reg   = wr_en_q;
            wb_data  = alu_res_q;
            state_nx = EXC_IDLE;
          end else begin
            state_nx = EXC_WB;
          end
        end else if (mem_timeout) begin
          state_nx = EXC_FAULT;
        end
      end
      EXC_WB: begin
        wb_reg   = wr_en_q;
        wb_high  = uop.high;
        wb_data  = rd_data;
        state_nx = EXC_IDLE;
      end
      EXC_FAULT: begin
        bus_err = 1'b1;
        if (fault_clr) state_nx = EXC_IDLE;
      end
      default: state_nx = EXC_IDLE;
    endcase
  end

  exec_ctl_memif #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) u_memif (
    .clk      (clk),
    .rst      (rst),
    .start    (mem_start),
    .active   (state == EXC_MEM),
    .addr     (alu_addr),
    .wdata    (wdata),
    .we       (uop.we),
    .io       (uop.m_io),
    .byteop   (uop.byteop),
    .ack      (mem_ack),
    .rdata    (mem_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_io   (mem_io),
    .mem_byte (mem_byte),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .rd_data  (rd_data),
    .done     (mem_done),
    .timeout  (mem_timeout)
  );

endmodule

// File: tb/tb_exec_ctl.sv
// Scoreboard bench for exec_ctl: a transaction-level model predicts readiness,
// bus request windows, faults and writeback events for random microinstructions.
module tb_exec_ctl;
  import exec_ctl_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 20;
  localparam int unsigned IRW = 36;
  localparam int unsigned TW  = 8;
  localparam int unsigned TMO = 4;
  localparam int unsigned N_RAND = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ir_valid = 1'b0;
  logic          ir_ready;
  logic [IRW-1:0] ir = '0;
  logic [DW-1:0] alu_res = '0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          dive = 1'b0;
  logic          jmp = 1'b0;
  logic          mem_req, mem_we, mem_io, mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wb_reg, wb_high, wb_flags;
  logic [DW-1:0] wb_data;
  logic          div_exc, bus_err;
  logic          fault_clr = 1'b0;

  exec_ctl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .IR_W   (IRW),
    .TMO_W  (TW),
    .TMO_MAX(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .alu_res(alu_res), .alu_addr(alu_addr), .wdata(wdata), .dive(dive), .jmp(jmp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_reg(wb_reg), .wb_high(wb_high), .wb_flags(wb_flags), .wb_data(wb_data),
    .div_exc(div_exc), .bus_err(bus_err), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic we, wr, wr_cnd, high, wrfl, byteop, mem_op, m_io, dive, jmp;
    logic [DW-1:0] alu, wdata, rdata;
    logic [AW-1:0] addr;
    logic [IRW-1:0] junk;
    int unsigned k;   // MEM cycle carrying the ack; beyond TMO means no ack in time
  } instr_t;

  typedef struct {
    int unsigned cyc;
    logic wreg, high, flags, div;
    logic [DW-1:0] data;
  } evt_t;

  instr_t dirq[$];
  evt_t   expq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t.mem_op = ($urandom_range(0, 2) == 0);
    t.we     = 1'($urandom);
    t.wr     = 1'($urandom);
    t.wr_cnd = 1'($urandom);
    t.high   = 1'($urandom);
    t.wrfl   = 1'($urandom);
    t.byteop = 1'($urandom);
    t.m_io   = 1'($urandom);
    t.jmp    = 1'($urandom);
    t.dive   = !t.mem_op && ($urandom_range(0, 3) == 0);
    t.alu    = DW'($urandom);
    t.wdata  = DW'($urandom);
    t.rdata  = DW'($urandom);
    t.addr   = AW'($urandom);
    t.junk   = IRW'({$urandom, $urandom});
    t.k      = $urandom_range(1, 6);
    return t;
  endfunction

  function automatic logic [IRW-1:0] pack_ir(input instr_t t);
    logic [IRW-1:0] v;
    v = t.junk;
    v[IR_WE] = t.we;     v[IR_WR] = t.wr;     v[IR_WR_CND] = t.wr_cnd; v[IR_HIGH] = t.high;
    v[IR_WRFL] = t.wrfl; v[IR_BYTEOP] = t.byteop; v[IR_MEM_OP] = t.mem_op; v[IR_M_IO] = t.m_io;
    return v;
  endfunction

  // Model bookkeeping, in absolute cycle numbers.
  instr_t nxt, cur, mreq;
  int ready_at = 0, exec_p = -1, ack_p = -1, clr_p = -1;
  int req_lo = 1, req_hi = 0, flt_lo = 1, flt_hi = 0;
  logic [DW-1:0] ack_data = '0;
  int n_left = 0;
  bit just_acc = 0;

  task automatic model(input int n, input instr_t t);
    logic wr_en;
    evt_t e;
    wr_en = t.wr | (t.wr_cnd & t.jmp);
    exec_p = n;
    cur = t;
    if (t.mem_op) begin
      mreq = t;
      req_lo = n + 1;
      ack_p = n + int'(t.k);
      ack_data = t.rdata;
      if (t.k <= TMO) begin
        req_hi = n + int'(t.k);
        if (t.we) begin
          e = '{cyc: n + t.k, wreg: 1'b1, high: 1'b0, flags: 1'b0, div: 1'b0, data: t.alu};
          if (wr_en) expq.push_back(e);
          ready_at = n + int'(t.k) + 1;
        end else begin
          e = '{cyc: n + t.k + 1, wreg: wr_en, high: t.high, flags: 1'b0, div: 1'b0,
                data: t.byteop ? (t.rdata & 16'h00FF) : t.rdata};
          if (wr_en || t.high) expq.push_back(e);
          ready_at = n + int'(t.k) + 2;
        end
      end else begin
        req_hi = n + int'(TMO);
        flt_lo = n + int'(TMO) + 1;
        clr_p  = flt_lo + int'($urandom_range(0, 3));
        flt_hi = clr_p;
        ready_at = clr_p + 1;
      end
    end else if (t.dive && t.wr) begin
      e = '{cyc: n, wreg: 1'b0, high: 1'b0, flags: 1'b0, div: 1'b1, data: '0};
      expq.push_back(e);
      ready_at = n + 1;
    end else begin
      e = '{cyc: n, wreg: wr_en, high: t.high, flags: t.wrfl, div: 1'b0, data: t.alu};
      if (wr_en || t.high || t.wrfl) expq.push_back(e);
      ready_at = n;
    end
  endtask

  task automatic step();
    int p;
    bit ready_m, acc, in_req;
    @(posedge clk);
    #1;
    p = int'(cyc);
    if (just_acc) ir_valid = 1'b0;
    just_acc = 0;
    if (p == exec_p) begin
      alu_res = cur.alu; alu_addr = cur.addr; wdata = cur.wdata; dive = cur.dive; jmp = cur.jmp;
    end else begin
      alu_res = DW'($urandom); alu_addr = AW'($urandom); wdata = DW'($urandom);
      dive = 1'($urandom); jmp = 1'($urandom);
    end
    mem_ack   = (p == ack_p);
    mem_rdata = (p == ack_p) ? ack_data : DW'($urandom);
    fault_clr = (p == clr_p);
    if (!ir_valid && n_left > 0 && (dirq.size() > 0 || $urandom_range(0, 3) != 0)) begin
      nxt = (dirq.size() > 0) ? dirq.pop_front() : rand_instr();
      ir = pack_ir(nxt);
      ir_valid = 1'b1;
      n_left--;
    end
    ready_m = (p >= ready_at);
    acc = ir_valid && ready_m;
    in_req = (p >= req_lo) && (p <= req_hi);
    @(negedge clk);
    chk("ir_ready", 64'(ir_ready), 64'(ready_m));
    chk("mem_req", 64'(mem_req), 64'(in_req));
    chk("bus_err", 64'(bus_err), 64'((p >= flt_lo) && (p <= flt_hi)));
    if (in_req) begin
      chk("mem_addr", 64'(mem_addr), 64'(mreq.addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(mreq.wdata));
      chk("mem_we", 64'(mem_we), 64'(mreq.we));
      chk("mem_io", 64'(mem_io), 64'(mreq.m_io));
      chk("mem_byte", 64'(mem_byte), 64'(mreq.byteop));
    end
    if (acc) begin
      model(p + 1, nxt);
      just_acc = 1;
    end
  endtask

  // Monitor: every strobe the DUT presents must match the oldest predicted event.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst && (wb_reg || wb_high || wb_flags || div_exc)) begin
        if (expq.size() == 0) begin
          chk("unexpected_strobe", 64'({wb_reg, wb_high, wb_flags, div_exc}), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("wb_cycle", 64'(cyc), 64'(e.cyc));
          chk("wb_reg", 64'(wb_reg), 64'(e.wreg));
          chk("wb_high", 64'(wb_high), 64'(e.high));
          chk("wb_flags", 64'(wb_flags), 64'(e.flags));
          chk("div_exc", 64'(div_exc), 64'(e.div));
          if (e.wreg || e.high || e.flags) chk("wb_data", 64'(wb_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    instr_t t;
    int guard;

    // Directed cases first, then random traffic.
    t = rand_instr(); t.mem_op = 0; t.dive = 0; t.wr = 1; t.wr_cnd = 0; t.high = 0; t.wrfl = 0;
    t.alu = 16'h1234; dirq.push_back(t);
    t.wr = 0; t.wr_cnd = 1; t.jmp = 0; t.alu = 16'h1111; dirq.push_back(t);
    t.jmp = 1; t.alu = 16'h2222; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 1; t.we = 0; t.wr = 1; t.byteop = 0; t.addr = 20'h12345;
    t.k = 3; t.rdata = 16'hBEEF; dirq.push_back(t);
    t.byteop = 1; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 0; t.dive = 1; t.wr = 1; t.high = 1; t.wrfl = 1; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 0; t.dive = 0; t.wr = 1; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 1; t.we = 0; t.k = 6; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 1; t.we = 0; t.wr = 1; t.k = 4; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 1; t.we = 1; t.wr = 1; t.k = 2; t.alu = 16'hA5A5; dirq.push_back(t);
    t = rand_instr(); t.mem_op = 1; t.we = 1; t.k = 5; dirq.push_back(t);
    n_left = dirq.size() + N_RAND;

    #12;
    chk("rst_ir_ready", 64'(ir_ready), 64'(1));
    chk("rst_mem", 64'({mem_req, mem_we, mem_io, mem_byte}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_wb", 64'({wb_reg, wb_high, wb_flags, div_exc, bus_err}), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    guard = 0;
    while ((n_left > 0 || ir_valid) && guard < 20000) begin
      step();
      guard++;
    end
    chk("issue_done", 64'(ir_valid), 64'(0));
    repeat (20) step();
    chk("exp_queue_empty", 64'(expq.size()), 64'(0));

    // Reset during an outstanding bus request abandons it.
    @(posedge clk); #1;
    mem_ack = 1'b0; fault_clr = 1'b0; dive = 1'b0;
    t = rand_instr(); t.mem_op = 1; t.we = 0; t.wr = 1;
    ir = pack_ir(t); ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0; alu_addr = 20'hABCDE;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(mem_req), 64'(1));
    #2; rst = 1'b0; #1;
    chk("rst_mid_req", 64'(mem_req), 64'(0));
    chk("rst_mid_ready", 64'(ir_ready), 64'(1));
    chk("rst_mid_err", 64'(bus_err), 64'(0));
    @(negedge clk); rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_req", 64'(mem_req), 64'(0));
    chk("post_rst_ready", 64'(ir_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
